// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_core transmitter among N_REQ byte requesters.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter logic [3:0]  ADDR_DATA = 4'h0,
    parameter logic [3:0]  ADDR_STAT = 4'h1,
    parameter int unsigned POLL_GAP  = 2
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic [3:0]           avm_address_o,
    output logic                 avm_read_o,
    output logic                 avm_write_o,
    output logic [7:0]           avm_writedata_o,
    input  logic [7:0]           avm_readdata_i
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned GAP_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL_RD,
        S_POLL_CHK,
        S_GAP,
        S_WRITE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         hold_q, hold_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [7:0]         win_data;

    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [3:0]         addr_q, addr_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [7:0]         wdata_q, wdata_d;

    logic [6:0]         unused_readdata;
    assign unused_readdata = avm_readdata_i[7:1];

`ifndef UART_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   last_q, last_d;
    logic               hi_found, lo_found;
    logic [IDX_W-1:0]   hi_idx, lo_idx;
`endif

    // Winner selection; descending scans leave the lowest qualifying index in place
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
`else
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                if (IDX_W'(i) > last_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(i);
                end
            end
        end
        win_found = hi_found | lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
`endif
        win_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_idx == IDX_W'(i)) win_data = req_data_i[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            last_q  <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
`ifndef UART_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
`ifndef UART_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_POLL_RD;
                    hold_d  = win_data;
                    idx_d   = win_idx;
                end
            end
            S_POLL_RD: state_d = S_POLL_CHK;
            // Status data returns one cycle after the read strobe
            S_POLL_CHK: begin
                if (avm_readdata_i[0]) begin
                    state_d = S_WRITE;
                end else if (POLL_GAP == 0) begin
                    state_d = S_POLL_RD;
                end else begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d = S_POLL_RD;
                    gap_d   = '0;
                end else begin
                    gap_d   = gap_q + GAP_W'(1);
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
`ifndef UART_ARB_FIXED_PRIO_EN
                last_d  = idx_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus/grant outputs are decoded from the next state so the flops track the state register
    always_comb begin
        req_ready_o = '0;
        grant_d     = '0;
        busy_d      = (state_d != S_IDLE);
        read_d      = (state_d == S_POLL_RD);
        write_d     = (state_d == S_WRITE);
        addr_d      = write_d ? ADDR_DATA : ADDR_STAT;
        wdata_d     = write_d ? hold_d : 8'h00;
        for (int i = 0; i < int'(N_REQ); i++) begin
            grant_d[i] = busy_d && (idx_d == IDX_W'(i));
            if (arst_n_i && (state_q == S_IDLE) && win_found && (win_idx == IDX_W'(i))) begin
                req_ready_o[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            addr_q  <= ADDR_STAT;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            grant_q <= grant_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    assign grant_o         = grant_q;
    assign busy_o          = busy_q;
    assign avm_address_o   = addr_q;
    assign avm_read_o      = read_q;
    assign avm_write_o     = write_q;
    assign avm_writedata_o = wdata_q;

endmodule
